// File: rtl/nn_route_pkg.sv
// Shared constants, FSM encoding and lane helpers for the LUT route sequencer.
package nn_route_pkg;
  localparam int LANES  = 10;
  localparam int WIDTH  = 16;
  localparam int ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } rs_state_e;

  function automatic logic [WIDTH-1:0] lane_slice(input logic [LANES*WIDTH-1:0] v,
                                                  input int unsigned k);
    return v[k*WIDTH +: WIDTH];
  endfunction
endpackage

// File: rtl/lane_unpack_pack.sv
// Indexed lane read mux plus one-hot lane write-enable decoder.
module lane_unpack_pack #(
  parameter int LANES = 10,
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic [LANES-1:0][WIDTH-1:0] buf_q,
  input  logic [CNT_W-1:0]            rd_idx,
  output logic [WIDTH-1:0]            rd_data,
  input  logic                        wr_en,
  input  logic [CNT_W-1:0]            wr_idx,
  output logic [LANES-1:0]            wr_sel
);
  // Out-of-range indices read as zero so the idle operand bus stays quiet.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < LANES; k++)
      if (rd_idx == CNT_W'(k)) rd_data = buf_q[k];
  end

  for (genvar k = 0; k < LANES; k++) begin : g_sel
    assign wr_sel[k] = wr_en && (wr_idx == CNT_W'(k));
  end
endmodule

// File: rtl/lut_route_sequencer.sv
// Serialises one MAC stage-1 vector through the shared activation LUT and
// reassembles the in-order responses into a vector for MAC stage 2.
module lut_route_sequencer
  import nn_route_pkg::*;
#(
  parameter int LANES  = nn_route_pkg::LANES,
  parameter int WIDTH  = nn_route_pkg::WIDTH,
  parameter int ADDR_W = nn_route_pkg::ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LANES*WIDTH-1:0] VecIn,
  input  logic                   VecInValid,
  output logic                   VecInReady,
  output logic                   LutReq,
  input  logic                   LutGnt,
  output logic [ADDR_W-1:0]      LutAddr,
  output logic [WIDTH-1:0]       LutDataOut,
  input  logic                   LutRspValid,
  input  logic [WIDTH-1:0]       LutDataIn,
  output logic [LANES*WIDTH-1:0] VecOut,
  output logic                   VecOutValid,
  input  logic                   VecOutReady,
  output logic                   Busy,
  output logic                   ErrRsp
);
  localparam int CW = ADDR_W + 1;

  rs_state_e                   state, state_nxt;
  logic [CW-1:0]               issue_cnt, rsp_cnt, issued_eff;
  logic [LANES-1:0][WIDTH-1:0] in_buf, out_buf;
  logic                        err;
  logic                        accept, fire, rsp_ok, rsp_last, issue_last;
  logic [WIDTH-1:0]            rd_data;
  logic [LANES-1:0]            wr_sel;

  assign accept     = (state == IDLE) && VecInValid;
  assign fire       = (state == ISSUE) && LutGnt;
  // A grant and its own response may share a cycle, so count this cycle's grant.
  assign issued_eff = issue_cnt + CW'(fire);
  assign rsp_ok     = LutRspValid && ((state == ISSUE) || (state == DRAIN)) &&
                      (rsp_cnt < issued_eff);
  assign rsp_last   = rsp_ok && (rsp_cnt == CW'(LANES - 1));
  assign issue_last = fire && (issue_cnt == CW'(LANES - 1));

  lane_unpack_pack #(.LANES(LANES), .WIDTH(WIDTH), .CNT_W(CW)) u_lanes (
    .buf_q   (in_buf),
    .rd_idx  (issue_cnt),
    .rd_data (rd_data),
    .wr_en   (rsp_ok),
    .wr_idx  (rsp_cnt),
    .wr_sel  (wr_sel)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (VecInValid) state_nxt = ISSUE;
      ISSUE:   if (rsp_last) state_nxt = HOLD;
               else if (issue_last) state_nxt = DRAIN;
      DRAIN:   if (rsp_last || (rsp_cnt == CW'(LANES))) state_nxt = HOLD;
      HOLD:    if (VecOutReady) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    VecInReady  = (state == IDLE);
    LutReq      = (state == ISSUE);
    LutAddr     = (state == ISSUE) ? issue_cnt[ADDR_W-1:0] : '0;
    LutDataOut  = (state == ISSUE) ? rd_data : '0;
    VecOutValid = (state == HOLD);
    Busy        = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issue_cnt <= '0;
      rsp_cnt   <= '0;
      in_buf    <= '0;
      out_buf   <= '0;
      err       <= 1'b0;
    end else begin
      if (accept) begin
        in_buf    <= VecIn;
        issue_cnt <= '0;
        rsp_cnt   <= '0;
      end else begin
        if (fire)   issue_cnt <= issue_cnt + CW'(1);
        if (rsp_ok) rsp_cnt   <= rsp_cnt + CW'(1);
      end
      for (int k = 0; k < LANES; k++)
        if (wr_sel[k]) out_buf[k] <= LutDataIn;
      // Stray responses are dropped but remembered until reset.
      if (LutRspValid && !rsp_ok) err <= 1'b1;
    end
  end

  assign VecOut = out_buf;
  assign ErrRsp = err;
endmodule

// File: tb/tb_lut_route_sequencer.sv
// Randomised bench: behavioural LUT with configurable latency/grant pattern and
// a vector-level reference (each lane passes through the LUT function once).
module tb_lut_route_sequencer;
  import nn_route_pkg::*;
  localparam int VW = LANES * WIDTH;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic [VW-1:0]     VecIn = '0;
  logic              VecInValid = 1'b0, VecInReady;
  logic              LutReq, LutGnt = 1'b0;
  logic [ADDR_W-1:0] LutAddr;
  logic [WIDTH-1:0]  LutDataOut, LutDataIn = '0;
  logic              LutRspValid = 1'b0;
  logic [VW-1:0]     VecOut;
  logic              VecOutValid, VecOutReady = 1'b0, Busy, ErrRsp;

  always #5 clk = ~clk;

  lut_route_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .VecIn(VecIn), .VecInValid(VecInValid), .VecInReady(VecInReady),
    .LutReq(LutReq), .LutGnt(LutGnt), .LutAddr(LutAddr), .LutDataOut(LutDataOut),
    .LutRspValid(LutRspValid), .LutDataIn(LutDataIn),
    .VecOut(VecOut), .VecOutValid(VecOutValid), .VecOutReady(VecOutReady),
    .Busy(Busy), .ErrRsp(ErrRsp)
  );

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] lut_f(input logic [WIDTH-1:0] x);
    return x + 16'd1;
  endfunction

  function automatic logic [VW-1:0] ref_out(input logic [VW-1:0] v);
    logic [VW-1:0] r;
    r = '0;
    for (int k = 0; k < LANES; k++) r[k*WIDTH +: WIDTH] = lut_f(lane_slice(v, k));
    return r;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*WIDTH +: WIDTH] = WIDTH'($urandom);
    return r;
  endfunction

  // ---------------- behavioural LUT (drives on negedge) ----------------
  typedef struct { logic [ADDR_W-1:0] a; logic [WIDTH-1:0] d; bit g; } req_rec_t;
  typedef struct { logic [WIDTH-1:0] d; int due; } pend_t;
  req_rec_t log_q[$];
  pend_t    pend[$];
  int cyc = 0, fire_cnt = 0, stall_hits = 0;
  int lat = 1, stall_until = 0, stall_lane = 3;
  bit rand_gnt = 1'b0, flush = 1'b0, inject = 1'b0;

  always @(negedge clk) begin
    bit g;
    g = rand_gnt ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (LutReq && int'(LutAddr) == stall_lane) begin
      if (stall_hits < stall_until) g = 1'b0;
      stall_hits++;
    end
    if (flush) begin
      pend.delete();
      g = 1'b0;
    end
    LutGnt = g;
    if (LutReq) log_q.push_back('{a: LutAddr, d: LutDataOut, g: g});
    if (LutReq && g) begin
      pend.push_back('{d: lut_f(LutDataOut), due: cyc + lat});
      fire_cnt++;
    end
    if (!flush && pend.size() > 0 && pend[0].due <= cyc) begin
      LutRspValid = 1'b1;
      LutDataIn   = pend[0].d;
      void'(pend.pop_front());
    end else begin
      LutRspValid = inject;
      LutDataIn   = inject ? 16'hDEAD : '0;
    end
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!VecOutValid && n < 300) begin
      tick();
      n++;
    end
  endtask

  task automatic consume(input string tag);
    VecOutReady = 1'b1;
    tick();
    VecOutReady = 1'b0;
    chk({tag, "_drop"}, VecOutValid, 1'b0);
    chk({tag, "_idle"}, VecInReady, 1'b1);
  endtask

  // exp_lat < 0 skips the latency check (random grant patterns).
  task automatic run_vec(input string tag, input logic [VW-1:0] v, input int exp_lat);
    int base, n, e;
    base = log_q.size();
    VecIn = v;
    VecInValid = 1'b1;
    tick();
    VecInValid = 1'b0;
    chk({tag, "_acc"}, Busy, 1'b1);
    wait_out(n);
    chk({tag, "_vld"}, VecOutValid, 1'b1);
    if (exp_lat >= 0) chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_vec"}, VecOut, ref_out(v));
    e = 0;
    for (int i = base; i < log_q.size(); i++) begin
      if (e >= LANES) begin
        chk({tag, "_extra_req"}, 1'b1, 1'b0);
        break;
      end
      chk({tag, "_addr"}, log_q[i].a, e);
      chk({tag, "_opnd"}, log_q[i].d, lane_slice(v, e));
      if (log_q[i].g) e++;
    end
    chk({tag, "_ngnt"}, e, LANES);
    consume(tag);
  endtask

  logic [VW-1:0] nom, v1, v2;
  int n, base;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < LANES; k++) nom[k*WIDTH +: WIDTH] = 16'h0100 + 16'(k);

    // Reset held for two edges.
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_inrdy", VecInReady, 1'b1);
    chk("rst_outvld", VecOutValid, 1'b0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_err", ErrRsp, 1'b0);
    chk("rst_vecout", VecOut, '0);
    chk("rst_req", LutReq, 1'b0);
    rst_n = 1'b1;
    tick();

    // Nominal: last response at accept+LANES+L, valid seen right after that edge.
    lat = 1;
    run_vec("nom", nom, LANES + 1);
    chk("nom_lane0", VecOut[WIDTH-1:0], 16'h0101);

    // Lane 3 refused four times: same result, four cycles later.
    stall_lane  = 3;
    stall_until = stall_hits + 4;
    run_vec("stall", nom, LANES + 1 + 4);

    // Zero-latency LUT: HOLD on the edge of the last grant.
    lat = 0;
    run_vec("zlat", rand_vec(), LANES);
    chk("noerr", ErrRsp, 1'b0);

    // Output backpressure with a competing input vector.
    lat = 1;
    v1 = rand_vec();
    v2 = rand_vec();
    VecIn = v1;
    VecInValid = 1'b1;
    tick();
    VecInValid = 1'b0;
    wait_out(n);
    chk("bp_vld", VecOutValid, 1'b1);
    VecIn = v2;
    VecInValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_vec", VecOut, ref_out(v1));
      chk("bp_hold_rdy", VecInReady, 1'b0);
      chk("bp_hold_vld", VecOutValid, 1'b1);
    end
    VecOutReady = 1'b1;
    tick();
    VecOutReady = 1'b0;
    chk("bp_idle_rdy", VecInReady, 1'b1);
    chk("bp_idle_busy", Busy, 1'b0);
    chk("bp_idle_vld", VecOutValid, 1'b0);
    tick();
    VecInValid = 1'b0;
    chk("bp_acc2", Busy, 1'b1);
    wait_out(n);
    chk("bp_vec2", VecOut, ref_out(v2));
    consume("bp2");

    // Reset after five grants, then a stray late response.
    lat = 1;
    base = fire_cnt;
    VecIn = rand_vec();
    VecInValid = 1'b1;
    tick();
    VecInValid = 1'b0;
    n = 0;
    while (fire_cnt - base < 5 && n < 100) begin
      tick();
      n++;
    end
    chk("mr_grants", fire_cnt - base, 5);
    rst_n = 1'b0;
    flush = 1'b1;
    tick();
    rst_n = 1'b1;
    flush = 1'b0;
    chk("mr_state", Busy, 1'b0);
    chk("mr_err_pre", ErrRsp, 1'b0);
    inject = 1'b1;
    tick();
    inject = 1'b0;
    chk("mr_err", ErrRsp, 1'b1);
    chk("mr_vld", VecOutValid, 1'b0);
    chk("mr_inrdy", VecInReady, 1'b1);
    run_vec("mr_next", rand_vec(), LANES + 1);
    chk("mr_sticky", ErrRsp, 1'b1);

    // Random data, latency and grant gaps.
    rand_gnt = 1'b1;
    for (int i = 0; i < 8; i++) begin
      lat = int'($urandom_range(0, 3));
      run_vec($sformatf("rnd%0d", i), rand_vec(), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
